uart_cmd_loader: RTL
====================

// Module: uart_cmd_loader
// PURPOSE
//  Consumes the byte stream from the UART receiver (8-bit data plus a 1-cycle valid strobe)
//  and parses host command packets. WRITE packets are turned into sequential memory write
//  requests (ROM/RAM download); CTRL packets update a control register (e.g. CPU hold/reset).
//  Sits between the UART receiver and the memory arbiter / system control logic.
// PARAMETERS
//  ADDR_W        24      memory address width; 3 address bytes always received, upper bits dropped
//  TIMEOUT_CYC   100000  idle cycles between bytes before the parser aborts to IDLE
//  CTRL_RESET    8'h00   reset value of ctrl_out
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       synchronous reset, active low
//  rx_data       in   8       received byte, valid when rx_valid=1
//  rx_valid      in   1       one-cycle strobe per received byte
//  mem_wr_req    out  1       write request, held until acked
//  mem_wr_addr   out  ADDR_W  write address
//  mem_wr_data   out  8       write data
//  mem_wr_ack    in   1       memory accepted the write this cycle
//  ctrl_out      out  8       control register written by CTRL packets
//  busy          out  1       parser is not in IDLE, or a write is pending
//  pkt_done      out  1       one-cycle pulse when a packet completes
//  err_overrun   out  1       sticky: a payload byte arrived while a write was still pending
//  err_csum      out  1       sticky: checksum mismatch (UART_CMD_LOADER_CSUM_EN only)
//  err_clr       in   1       clears both sticky error flags
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0,
//   ctrl_out=CTRL_RESET, pkt_done=0, err_*=0, timeout counter=0. A pending write is dropped.
//  Packet: CMD, then fields; multi-byte fields are sent LSB first.
//   CMD 8'h01 WRITE: A0 A1 A2, L0 L1 (16-bit length), L payload bytes [, CSUM].
//   CMD 8'h02 CTRL : V [, CSUM] -> ctrl_out<=V (with CSUM_EN: only if CSUM matches).
//   Any other CMD is ignored; state stays IDLE, no error.
//  FSM: IDLE -> ADDR0 -> ADDR1 -> ADDR2 -> LEN0 -> LEN1 -> DATA -> [CSUM] -> IDLE;
//   IDLE -> CTRLV -> [CSUM] -> IDLE. Exactly one transition per rx_valid.
//  L=0: LEN1 goes directly to CSUM (or to IDLE with pkt_done). No writes are issued.
//  DATA: each byte sets mem_wr_req=1 with mem_wr_data=byte and mem_wr_addr=current addr on
//   the next cycle (1-cycle latency). The address increments after each ack and wraps modulo
//   2^ADDR_W. The remaining count decrements per byte received; the last byte moves to the
//   next state.
//  Handshake: mem_wr_req, mem_wr_addr and mem_wr_data stay stable until a cycle with
//   mem_wr_ack=1; mem_wr_req drops on the following cycle. An ack while req=0 is ignored.
//  Overrun: rx_valid in DATA while req=1 and ack=0 -> the byte is dropped, err_overrun=1,
//   the count still decrements, and the address does not advance for the dropped byte.
//   rx_valid in the same cycle as ack is accepted.
//  pkt_done pulses on the cycle after the final packet byte. For WRITE it waits until the
//   last write is acked; busy stays 1 until then.
//  Timeout: the counter resets on every rx_valid. If the state is not IDLE and the counter
//   reaches TIMEOUT_CYC-1, the state goes to IDLE with no pkt_done. A pending write is
//   still completed.
//  err_clr has priority over setting an error flag in the same cycle.
//  rx_valid is ignored while rst_n=0.
// CONFIGURATION
//  UART_CMD_LOADER_CSUM_EN defined: every packet ends with CSUM = 8-bit sum (mod 256) of
//   all preceding packet bytes, CMD included.
//   - Mismatch: err_csum=1 and pkt_done still pulses.
//   - WRITE payload is streamed to memory regardless of the CSUM result.
//   - CTRL is applied only on a match.
//  Undefined: there is no CSUM state; err_csum is tied to 0 and CTRL is applied on its V byte.
// TESTING
//  1 Reset: drive rst_n=0 mid-DATA with req=1 -> all outputs at reset values, and the next
//    CMD byte is parsed from IDLE.
//  2 WRITE 01 00 10 00 03 00 AA BB CC (ack 2 cycles after each req) -> writes 0x001000=AA,
//    0x001001=BB, 0x001002=CC; one pkt_done; err_*=0.
//  3 CTRL 02 5A -> ctrl_out=0x5A. With CSUM_EN, 02 5A 5C -> ctrl_out=5A; 02 5A 00 -> err_csum=1
//    and ctrl_out unchanged.
//  4 Wrap: ADDR_W=16, WRITE to FFFF with L=2 -> writes at FFFF then 0000.
//  5 Overrun: hold ack=0 while sending 2 payload bytes -> err_overrun=1, only the first byte
//    is written; err_clr -> 0.
//  6 Timeout and edge cases: send 01 00 and then idle TIMEOUT_CYC cycles -> IDLE, busy=0, no
//    pkt_done. L=0 packet -> no mem_wr_req and one pkt_done. CMD 0x7F -> ignored.

Source files
------------

// File: rtl/uart_cmd_loader.sv
// Host command parser for the UART byte stream: WRITE packets become sequential memory writes,
// CTRL packets load ctrl_out. Optional trailing checksum enabled by UART_CMD_LOADER_CSUM_EN.
module uart_cmd_loader #(
  parameter int         ADDR_W      = 24,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] CTRL_RESET  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  input  logic              mem_wr_ack,
  output logic [7:0]        ctrl_out,
  output logic              busy,
  output logic              pkt_done,
  output logic              err_overrun,
  output logic              err_csum,
  input  logic              err_clr
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_LEN0, S_LEN1, S_DATA, S_CTRLV
`ifdef UART_CMD_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            state;
  logic [15:0]       tmp;
  logic [15:0]       remain;
  logic [ADDR_W-1:0] cur_addr;
  logic [TO_W-1:0]   idle_cnt;
  logic              done_pend;
  logic              stall;

`ifdef UART_CMD_LOADER_CSUM_EN
  logic [7:0] sum;
  logic       is_ctrl;
  logic       err_csum_r;
  assign err_csum = err_csum_r;
`else
  assign err_csum = 1'b0;
`endif

  // a write that will still be outstanding after this edge
  assign stall = mem_wr_req && !mem_wr_ack;
  assign busy  = (state != S_IDLE) || mem_wr_req || done_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tmp         <= '0;
      remain      <= '0;
      cur_addr    <= '0;
      idle_cnt    <= '0;
      done_pend   <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      ctrl_out    <= CTRL_RESET;
      pkt_done    <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_CMD_LOADER_CSUM_EN
      sum         <= '0;
      is_ctrl     <= 1'b0;
      err_csum_r  <= 1'b0;
`endif
    end else begin
      pkt_done <= 1'b0;
      if (mem_wr_req && mem_wr_ack) begin
        mem_wr_req <= 1'b0;
        if (done_pend) begin
          pkt_done  <= 1'b1;
          done_pend <= 1'b0;
        end
      end

      if (rx_valid) begin
        idle_cnt <= '0;
`ifdef UART_CMD_LOADER_CSUM_EN
        sum <= sum + rx_data;
`endif
        case (state)
          S_IDLE: begin
`ifdef UART_CMD_LOADER_CSUM_EN
            sum     <= rx_data;
            is_ctrl <= (rx_data == 8'h02);
`endif
            if (rx_data == 8'h01)      state <= S_ADDR0;
            else if (rx_data == 8'h02) state <= S_CTRLV;
          end
          S_ADDR0: begin tmp[7:0]  <= rx_data; state <= S_ADDR1; end
          S_ADDR1: begin tmp[15:8] <= rx_data; state <= S_ADDR2; end
          S_ADDR2: begin
            cur_addr <= ADDR_W'({rx_data, tmp});
            state    <= S_LEN0;
          end
          S_LEN0: begin tmp[7:0] <= rx_data; state <= S_LEN1; end
          S_LEN1: begin
            remain <= {rx_data, tmp[7:0]};
            if ({rx_data, tmp[7:0]} == 16'd0) begin
`ifdef UART_CMD_LOADER_CSUM_EN
              state <= S_CSUM;
`else
              state <= S_IDLE;
              if (stall) done_pend <= 1'b1;
              else       pkt_done  <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            // dropped bytes still count against the length but never advance the address
            if (stall) begin
              err_overrun <= 1'b1;
            end else begin
              mem_wr_req  <= 1'b1;
              mem_wr_addr <= cur_addr;
              mem_wr_data <= rx_data;
              cur_addr    <= cur_addr + ADDR_W'(1);
            end
            remain <= remain - 16'd1;
            if (remain == 16'd1) begin
`ifdef UART_CMD_LOADER_CSUM_EN
              state <= S_CSUM;
`else
              state     <= S_IDLE;
              done_pend <= 1'b1;
`endif
            end
          end
          S_CTRLV: begin
`ifdef UART_CMD_LOADER_CSUM_EN
            tmp[7:0] <= rx_data;
            state    <= S_CSUM;
`else
            ctrl_out <= rx_data;
            pkt_done <= 1'b1;
            state    <= S_IDLE;
`endif
          end
`ifdef UART_CMD_LOADER_CSUM_EN
          S_CSUM: begin
            state <= S_IDLE;
            if (rx_data != sum) err_csum_r <= 1'b1;
            if (is_ctrl) begin
              if (rx_data == sum) ctrl_out <= tmp[7:0];
              pkt_done <= 1'b1;
            end else if (stall) begin
              done_pend <= 1'b1;
            end else begin
              pkt_done <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // abandon a stalled packet; any outstanding write still completes
        if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state    <= S_IDLE;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end

      if (err_clr) begin
        err_overrun <= 1'b0;
`ifdef UART_CMD_LOADER_CSUM_EN
        err_csum_r  <= 1'b0;
`endif
      end
    end
  end

endmodule
